// File: rtl/pack_set.sv
// rtl/pack_set.sv - packs 4x15-bit coefficient lanes into a dense 64-bit stream
//
// Purpose: strips the unused MSB of each 16-bit lane (60 bits per input word)
// and re-packs the bits into 64-bit output words, earliest bit at the MSB.
// In bypass (sec_lvl != 0), words pass straight through and the pack state is frozen.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sec_lvl[1:0]              0 = pack, otherwise bypass
//   packIn/_val/_rdy          64-bit input stream (lane 3 is first in the stream)
//   packOut/_val/_rdy         64-bit packed output stream
//   full                      buffer cannot take another 60-bit group
//   lane_err                  sticky: a lane MSB was set on an accepted pack-mode word
//   frame_done                1-cycle pulse after every 15th output handshake
module pack_set (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sec_lvl,
    input  logic [63:0] packIn,
    input  logic        packIn_val,
    output logic        packIn_rdy,
    output logic [63:0] packOut,
    output logic        packOut_val,
    input  logic        packOut_rdy,
    output logic        full,
    output logic        lane_err,
    output logic        frame_done
);

    logic [127:0] buffer;
    logic [6:0]   buf_bits;
    logic [3:0]   incnt;
    logic [3:0]   outcnt;

    logic         pack_mode;
    logic         pk_full;
    logic         pk_val;
    logic [127:0] aligned;
    logic [59:0]  g60;
    logic         acc;
    logic         snd;

    assign pack_mode = (sec_lvl == 2'd0);
    assign pk_full   = (buf_bits > 7'd64);
    assign pk_val    = (buf_bits >= 7'd64);

    // Valid bits are right-aligned, oldest on top: shifting down by
    // (buf_bits - 64) puts the 64 oldest bits into the low half.
    assign aligned = buffer >> (buf_bits - 7'd64);

    assign g60 = {packIn[62:48], packIn[46:32], packIn[30:16], packIn[14:0]};

    always_comb begin
        packIn_rdy  = 1'b0;
        packOut_val = 1'b0;
        packOut     = 64'd0;
        full        = 1'b0;
        if (pack_mode) begin
            // Input readiness depends only on fill level, never on packOut_rdy.
            packIn_rdy  = ~pk_full;
            packOut_val = pk_val;
            packOut     = pk_val ? aligned[63:0] : 64'd0;
            full        = pk_full;
        end else begin
            packIn_rdy  = packOut_rdy;
            packOut_val = packIn_val;
            packOut     = packIn;
        end
    end

    assign acc = packIn_val & packIn_rdy;
    assign snd = packOut_val & packOut_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buffer     <= 128'd0;
            buf_bits   <= 7'd0;
            incnt      <= 4'd0;
            outcnt     <= 4'd0;
            lane_err   <= 1'b0;
            frame_done <= 1'b0;
        end else if (pack_mode) begin
            if (acc) begin
                // Bits shifted past bit 127 were already consumed by snd.
                buffer <= {buffer[67:0], g60};
                incnt  <= incnt + 4'd1;
                if (packIn[63] | packIn[47] | packIn[31] | packIn[15])
                    lane_err <= 1'b1;
            end

            case ({acc, snd})
                2'b10:   buf_bits <= buf_bits + 7'd60;
                2'b01:   buf_bits <= buf_bits - 7'd64;
                2'b11:   buf_bits <= buf_bits - 7'd4;
                default: buf_bits <= buf_bits;
            endcase

            if (snd)
                outcnt <= (outcnt == 4'd14) ? 4'd0 : outcnt + 4'd1;
            frame_done <= snd && (outcnt == 4'd14);
        end
    end

endmodule
